sum_sched: RTL
==============

# sum_sched

Scheduler that shares the single combinational `Sum` adder of the SimpleCPU datapath between several requesters. It arbitrates pending add requests round-robin, sequences one operation at a time through the adder (operand issue, result capture, response), and keeps a circular history of the last `LOG_DEPTH` results. It sits between the requesting units (decode, address, loop logic) and the adder instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 2, operand width; results are `DATA_W+1` bits
- `LOG_DEPTH`, 10, entries in the result history ring
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  N_REQ  per-requester request; held high until its `req_ready` bit is seen
- `req_a`, `req_b`  in  N_REQ*DATA_W  packed operands; requester i uses bits [i*DATA_W +: DATA_W]
- `req_ready`  out  N_REQ  one-hot grant; the handshake completes on a cycle where valid and ready are both high
- `add_en`  out  1  drives the adder's `sum` enable
- `add_a`, `add_b`  out  DATA_W  adder operands
- `add_sum`  in  DATA_W+1  adder result
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts the result
- `rsp_id`  out  $clog2(N_REQ)  requester index of the result
- `rsp_sum`  out  DATA_W+1  result value
- `log_rd_idx`  in  $clog2(LOG_DEPTH)  history read address
- `log_rd_data`  out  DATA_W+1  combinational read of entry `log_rd_idx`; indices ≥ LOG_DEPTH read 0
- `log_count`  out  $clog2(LOG_DEPTH+1)  valid entries, saturating at LOG_DEPTH
- `log_wr_ptr`  out  $clog2(LOG_DEPTH)  index the next result is written to

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: `req_ready` is 0 when no `req_valid` bit is set. Otherwise it is one-hot, selecting the first valid requester found by searching from `last_grant+1` upward modulo N_REQ.
  - On the edge that completes the handshake, the state machine latches the grantee's operands and id, sets `last_grant` to the grantee, and goes to EXEC.
- EXEC: `add_en`=1 and `add_a`/`add_b` come from the latched operands.
  - On the edge, `add_sum` is captured into the result register.
  - The same value is written to `log[log_wr_ptr]`. `log_wr_ptr` increments, wrapping from LOG_DEPTH-1 to 0. `log_count` increments unless it is already LOG_DEPTH.
  - Next state is RESP.
- RESP: `rsp_valid`=1. `rsp_id` and `rsp_sum` are stable until the `rsp_valid & rsp_ready` edge, which returns the FSM to IDLE.
- Outside EXEC: `add_en`=0 and `add_a`/`add_b`=0. The adder is never enabled in IDLE or RESP.
- `req_ready` is 0 in EXEC and RESP. New requests wait in IDLE and are never dropped.
- Arithmetic: unsigned. The result is taken from `add_sum` without modification; the full carry is kept in bit DATA_W.
- Overflowing the log overwrites the oldest entry. `log_count` stays at LOG_DEPTH.

## Timing
- Reset values (async assert on `rst_n`=0, released synchronously by the next edge after deassertion):
  - FSM state: IDLE
  - `last_grant`: N_REQ-1, so requester 0 has first priority
  - Outputs: `req_ready`=0 (no valid inputs), `add_en`=0, `add_a`=`add_b`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0
  - Log: all entries 0, `log_count`=0, `log_wr_ptr`=0
- Latency: handshake edge T → `add_en` high during cycle T+1 → `rsp_valid` high from cycle T+2.
- Minimum spacing is 3 cycles per operation, reached when `rsp_ready` is held high.
- Back-to-back: `rsp_ready` high in RESP gives IDLE on the next cycle, where the next grant can complete.
- Simultaneous requests: exactly one grant per IDLE cycle, in rotating priority. A requester waits at most N_REQ-1 other grants.
- Reset mid-operation: any in-flight EXEC or RESP operation is discarded. No response is produced, the log is cleared, and the requester must re-request.
- `rsp_ready` high while `rsp_valid`=0 has no effect.

## Test plan
- Reset then single request: req 2 with a=3, b=2 → `req_ready`=4'b0100 in that cycle, `add_en`=1 for exactly one cycle, `rsp_valid` 2 cycles after the handshake with `rsp_id`=2 and `rsp_sum`=5, `log_count`=1, log[0]=5.
- All 4 requesters valid continuously with `rsp_ready`=1 → grants in order 0,1,2,3,0,… with one response every 3 cycles; `add_en` never high in IDLE or RESP.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP → `rsp_sum`/`rsp_id` stable, `req_ready` stays 0; the first grant completes in the cycle after `rsp_ready` rises.
- Log wrap: 12 operations with sums 0,1,…,6,0,1,2,3,4 → `log_count`=10, `log_wr_ptr`=2, log[0]=3, log[1]=4, log[9]=2; `log_rd_idx`=12 reads 0.
- Reset during EXEC (req 1, a=3, b=3) → `rsp_valid` never rises, `add_en` drops immediately, `log_count`=0; after release, a fresh request from 1 gives `rsp_sum`=6.
- Fairness after reset: only requesters 3 and 1 valid → grant 1 first, then 3, then 1.

Source files
------------

// File: rtl/sum_sched.sv
// sum_sched: round-robin scheduler that time-shares one combinational adder
// between N_REQ requesters. It runs one operation at a time (grant, adder
// issue, response) and keeps a circular history of the last LOG_DEPTH results.
module sum_sched #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 2,
  parameter int LOG_DEPTH = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ*DATA_W-1:0]          req_a,
  input  logic [N_REQ*DATA_W-1:0]          req_b,
  output logic [N_REQ-1:0]                 req_ready,
  output logic                             add_en,
  output logic [DATA_W-1:0]                add_a,
  output logic [DATA_W-1:0]                add_b,
  input  logic [DATA_W:0]                  add_sum,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [$clog2(N_REQ)-1:0]         rsp_id,
  output logic [DATA_W:0]                  rsp_sum,
  input  logic [$clog2(LOG_DEPTH)-1:0]     log_rd_idx,
  output logic [DATA_W:0]                  log_rd_data,
  output logic [$clog2(LOG_DEPTH+1)-1:0]   log_count,
  output logic [$clog2(LOG_DEPTH)-1:0]     log_wr_ptr
);

  localparam int IDW = $clog2(N_REQ);
  localparam int LPW = $clog2(LOG_DEPTH);
  localparam int LCW = $clog2(LOG_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      last_grant_q, last_grant_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [DATA_W:0]     res_q, res_d;
  logic [LPW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [LCW-1:0]      count_q, count_d;
  logic [DATA_W:0]     log_q [LOG_DEPTH];
  logic                log_we;

  logic                grant_found;
  logic [IDW-1:0]      grant_idx;
  logic [IDW-1:0]      cand_idx;
  logic [DATA_W-1:0]   grant_a, grant_b;

  // Rotating-priority search: first valid requester after last_grant, modulo N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_idx = IDW'((int'(last_grant_q) + k) % N_REQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Operand mux for the requester currently selected by the arbiter.
  always_comb begin
    grant_a = '0;
    grant_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        grant_a = req_a[i*DATA_W +: DATA_W];
        grant_b = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and output decode for the IDLE/EXEC/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    res_d        = res_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    log_we       = 1'b0;
    req_ready    = '0;
    add_en       = 1'b0;
    add_a        = '0;
    add_b        = '0;
    rsp_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          // The selected bit is known valid, so the handshake completes now.
          req_ready[grant_idx] = 1'b1;
          op_a_d       = grant_a;
          op_b_d       = grant_b;
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        add_en   = 1'b1;
        add_a    = op_a_q;
        add_b    = op_b_q;
        res_d    = add_sum;
        log_we   = 1'b1;
        wr_ptr_d = (wr_ptr_q == LPW'(LOG_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (count_q != LCW'(LOG_DEPTH)) begin
          count_d = count_q + 1'b1;
        end
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer and operation registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(N_REQ - 1);
      id_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      res_q        <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      res_q        <= res_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // Result history ring; cleared on reset so stale results never read back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LOG_DEPTH; i++) begin
        log_q[i] <= '0;
      end
    end else if (log_we) begin
      log_q[wr_ptr_q] <= res_d;
    end
  end

  assign rsp_id      = id_q;
  assign rsp_sum     = res_q;
  assign log_count   = count_q;
  assign log_wr_ptr  = wr_ptr_q;
  assign log_rd_data = ({1'b0, log_rd_idx} < (LPW + 1)'(LOG_DEPTH)) ? log_q[log_rd_idx] : '0;

endmodule
